// File: rtl/imm_pack_loader.sv
// Boot-time instruction loader: packs immediate + upper fields into 28-bit words
// and streams them through a small FIFO into instruction memory.
module imm_pack_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [11:0]       in_head,
  input  logic [18:0]       in_imm,
  input  logic              mem_wait,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [27:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              ovf_err,
  output logic [7:0]        ovf_count,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  WC_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  // Handshake: a word transfers on any rising edge where in_valid && in_ready;
  // in_ready never depends on in_valid, and in_valid/fields must hold until taken.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [ADDR_W:0]     wc_q, wc_d;
  logic [ADDR_W:0]     accepted_q, accepted_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      cnt_q, cnt_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [27:0]         mem_wdata_q, mem_wdata_d;
  logic                ovf_err_q, ovf_err_d;
  logic [7:0]          ovf_count_q, ovf_count_d;
  logic [28:0]         fifo_q [DEPTH];

  logic [27:0] pack_word;
  logic        pack_ovf;
  logic        fifo_full, fifo_empty, held, push, pop;
  logic [28:0] head_entry;

  always_comb begin
    pack_word = {in_head[8:0], in_imm};
    pack_ovf  = 1'b0;
    case (in_fmt)
      2'b10: begin
        pack_word = {in_head[10:0], in_imm[16:0]};
        pack_ovf  = |in_imm[18:17];
      end
      2'b11: begin
        pack_word = {in_head[11:0], in_imm[15:0]};
        pack_ovf  = |in_imm[18:16];
      end
      default: ;
    endcase
  end

  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_empty = (cnt_q == '0);
  assign held       = mem_we_q & mem_wait;
  assign in_ready   = (state_q == S_LOAD) && !fifo_full && (accepted_q < wc_q);
  assign push       = in_valid & in_ready;
  assign pop        = (state_q == S_LOAD) && !fifo_empty && !held;
  assign head_entry = fifo_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    wc_d        = wc_q;
    accepted_d  = accepted_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ovf_err_d   = ovf_err_q;
    ovf_count_d = ovf_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_addr_d  = base_addr;
          remaining_d = word_count;
          wc_d        = word_count;
          accepted_d  = '0;
          ovf_err_d   = 1'b0;
          ovf_count_d = '0;
          state_d     = (word_count == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (remaining_q == '0 && !held) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      wr_ptr_d   = wr_ptr_q + PTR_ONE;
      accepted_d = accepted_q + WC_ONE;
    end

    // A popped overflow word still consumes its address slot so layout is kept.
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      cur_addr_d  = cur_addr_q + ADDR_ONE;
      remaining_d = remaining_q - WC_ONE;
      if (head_entry[0]) begin
        mem_we_d  = 1'b0;
        ovf_err_d = 1'b1;
        if (ovf_count_q != 8'hFF) ovf_count_d = ovf_count_q + 8'd1;
      end else begin
        mem_we_d    = 1'b1;
        mem_addr_d  = cur_addr_q;
        mem_wdata_d = head_entry[28:1];
      end
    end else if (!held) begin
      mem_we_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      wc_q        <= '0;
      accepted_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ovf_err_q   <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      wc_q        <= wc_d;
      accepted_q  <= accepted_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ovf_err_q   <= ovf_err_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {pack_word, pack_ovf};
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == S_LOAD);
  assign done      = (state_q == S_DONE);
  assign ovf_err   = ovf_err_q;
  assign ovf_count = ovf_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_imm_pack_loader.sv
// Self-checking bench for imm_pack_loader: directed scenarios plus randomized
// loads checked against a word-list model of the packing and address rules.
module tb_imm_pack_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_fmt;
  logic [11:0]       in_head;
  logic [18:0]       in_imm;
  logic              mem_wait;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [27:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              ovf_err;
  logic [7:0]        ovf_count;
  logic [1:0]        dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [1:0]  w_fmt[$];
  logic [11:0] w_head[$];
  logic [18:0] w_imm[$];
  logic [35:0] exp_q[$];
  int          exp_novf;

  imm_pack_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_head(in_head), .in_imm(in_imm), .mem_wait(mem_wait),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .ovf_err(ovf_err), .ovf_count(ovf_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_words();
    w_fmt.delete(); w_head.delete(); w_imm.delete();
  endtask

  task automatic push_word(input logic [1:0] f, input logic [11:0] h, input logic [18:0] i);
    w_fmt.push_back(f); w_head.push_back(h); w_imm.push_back(i);
  endtask

  task automatic gen_words(input int n, input int ovf_pct);
    for (int k = 0; k < n; k++) begin
      logic [1:0]  f;
      logic [18:0] im;
      int unsigned lim;
      f   = 2'($urandom_range(0, 3));
      lim = (f == 2'd3) ? 65536 : (f == 2'd2) ? 131072 : 524288;
      if (lim < 524288 && $urandom_range(1, 100) <= ovf_pct)
        im = 19'($urandom_range(lim, 524287));
      else
        im = 19'($urandom_range(0, lim - 1));
      push_word(f, 12'($urandom_range(0, 4095)), im);
    end
  endtask

  // Each word lands at base+index; overflowed words are skipped but keep their slot.
  task automatic build_model(input logic [ADDR_W-1:0] base);
    exp_q.delete();
    exp_novf = 0;
    for (int k = 0; k < w_fmt.size(); k++) begin
      int unsigned h, im, d;
      bit ov;
      h  = w_head[k];
      im = w_imm[k];
      case (w_fmt[k])
        2'd3:    begin d = (h % 4096) * 65536 + (im % 65536);   ov = (im >= 65536);  end
        2'd2:    begin d = (h % 2048) * 131072 + (im % 131072); ov = (im >= 131072); end
        default: begin d = (h % 512) * 524288 + im;             ov = 1'b0;          end
      endcase
      if (ov) exp_novf++;
      else exp_q.push_back({8'((int'(base) + k) % 256), 28'(d)});
    end
  endtask

  task automatic run_load(input logic [ADDR_W-1:0] base, input int count, input int valid_pct,
                          input int wait_pct, input int stall_cycles, input int abort_after,
                          input bit b2b);
    int idx, retired, last_ret;
    bit seen_done, was_held;
    logic [ADDR_W-1:0] h_addr;
    logic [27:0] h_data;
    logic [35:0] e;
    build_model(base);
    idx = 0; retired = 0; last_ret = 0; seen_done = 0; was_held = 0;
    h_addr = '0; h_data = '0;
    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = (ADDR_W+1)'(count);
    in_valid = 1'b0; mem_wait = 1'b0;
    for (int cyc = 1; cyc <= 400 && !seen_done; cyc++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = (idx < count) && ($urandom_range(1, 100) <= valid_pct);
      if (idx < count) begin
        in_fmt = w_fmt[idx]; in_head = w_head[idx]; in_imm = w_imm[idx];
      end else begin
        in_fmt = 2'($urandom); in_head = 12'($urandom); in_imm = 19'($urandom);
      end
      mem_wait = (cyc <= stall_cycles) ? 1'b1 : ($urandom_range(1, 100) <= wait_pct);
      #1;
      if (was_held) begin
        chk("hold_we", mem_we, 1);
        chk("hold_addr", mem_addr, h_addr);
        chk("hold_data", mem_wdata, h_data);
      end
      if (done) begin
        seen_done = 1'b1;
        chk("done_writes_left", exp_q.size(), 0);
        chk("done_ovf_err", ovf_err, (exp_novf > 0));
        chk("done_ovf_count", ovf_count, (exp_novf > 255) ? 255 : exp_novf);
        chk("done_we", mem_we, 0);
      end else begin
        chk("busy", busy, 1);
      end
      if (stall_cycles > 0 && cyc == stall_cycles) begin
        chk("stall_accepts", idx, DEPTH + 1);
        chk("stall_ready", in_ready, 0);
      end
      if (idx >= count) chk("ready_limit", in_ready, 0);
      if (mem_we && !mem_wait) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", mem_we, 0);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", mem_addr, e[35:28]);
          chk("write_data", mem_wdata, e[27:0]);
          if (b2b && retired > 0) chk("b2b_gap", cyc - last_ret, 1);
        end
        last_ret = cyc;
        retired++;
      end
      was_held = mem_we && mem_wait;
      h_addr   = mem_addr;
      h_data   = mem_wdata;
      if (in_valid && in_ready) idx++;
      if (abort_after > 0 && retired == abort_after) break;
    end
    if (abort_after == 0) begin
      chk("done_seen", seen_done, 1);
      @(negedge clk);
      in_valid = 1'b0; mem_wait = 1'b0;
      #1;
      chk("done_pulse_width", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_we", mem_we, 0);
      chk("idle_ready", in_ready, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, dbg_state, 0);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf_err"}, ovf_err, 0);
    chk({tag, "_ovf_count"}, ovf_count, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; in_valid = 1'b0;
    in_fmt = '0; in_head = '0; in_imm = '0; mem_wait = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("reset");

    // Single fmt11 word at 0x10.
    clear_words(); push_word(2'b11, 12'hFFF, 19'h0ABCD);
    run_load(8'h10, 1, 100, 0, 0, 0, 0);

    // fmt00 with a full-width immediate never overflows.
    clear_words(); push_word(2'b00, 12'h1A5, 19'h7FFFF);
    run_load(8'h20, 1, 100, 0, 0, 0, 0);

    // Middle fmt10 word overflows and is skipped.
    clear_words();
    push_word(2'b10, 12'h123, 19'h00042);
    push_word(2'b10, 12'h456, 19'h20000);
    push_word(2'b10, 12'h789, 19'h1FFFF);
    run_load(8'h40, 3, 100, 0, 0, 0, 0);

    // Address wrap with back-to-back writes.
    clear_words(); gen_words(4, 0);
    run_load(8'hFE, 4, 100, 0, 0, 0, 1);

    // Memory stall fills the FIFO; release must neither lose nor duplicate words.
    clear_words(); gen_words(8, 0);
    run_load(8'h80, 8, 100, 0, 6, 0, 0);

    // Reset mid-load after two writes, then a clean reload.
    clear_words(); gen_words(5, 0);
    run_load(8'h30, 5, 100, 0, 0, 2, 0);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; mem_wait = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("midreset");
    reset = 1'b0;
    clear_words(); gen_words(5, 30);
    run_load(8'h30, 5, 100, 0, 0, 0, 0);

    // Empty load.
    clear_words();
    run_load(8'h55, 0, 100, 0, 0, 0, 0);

    // Randomized loads with ragged valid and memory stalls.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 20);
      clear_words(); gen_words(n, 25);
      run_load(8'($urandom_range(0, 255)), n, 70, 30, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
